// File: rtl/conv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv_pool_engine
// Purpose  : Reads a square 2^LOG_W x 2^LOG_W image from the image ROM and
//            runs a KxK dilated convolution with a runtime-loaded kernel and
//            bias, followed by ReLU. The result is written to layer-0
//            (csel=0). An optional 2x2 max-pool with round-up to an integer
//            then writes layer-1 (csel=1).
// Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   ready     in   start request, sampled in IDLE
//   busy      out  high from the cycle after start until one cycle into DONE
//   kw_en     in   kernel/bias write strobe (ignored while busy)
//   kw_addr   in   0..K*K-1 kernel taps (row-major), K*K = bias
//   kw_data   in   signed coefficient
//   pool_en   in   latched at start: run the layer-1 pooling pass
//   pad_rep   in   latched at start: 0 = zero padding, 1 = replicate edge
//   iaddr     out  image address {row,col}
//   idata     in   image data, valid the cycle after iaddr is registered
//   cwr       out  layer RAM write enable
//   caddr_wr  out  layer RAM write address
//   cdata_wr  out  layer RAM write data
//   crd       out  layer RAM read enable
//   caddr_rd  out  layer RAM read address
//   cdata_rd  in   layer RAM read data, valid the cycle after caddr_rd
//   csel      out  0 = layer-0 bank, 1 = layer-1 bank
// Configuration macro
//   CONV_SAT_EN : saturate layer-0 results and the layer-1 round-up at
//                 2^(DW-1)-1 instead of wrapping.
// ============================================================================
module conv_pool_engine #(
  parameter int LOG_W = 6,
  parameter int K     = 5,
  parameter int DIL   = 1,
  parameter int DW    = 13,
  parameter int FRAC  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  output logic               busy,
  input  logic               kw_en,
  input  logic [5:0]         kw_addr,
  input  logic [DW-1:0]      kw_data,
  input  logic               pool_en,
  input  logic               pad_rep,
  output logic [2*LOG_W-1:0] iaddr,
  input  logic [DW-1:0]      idata,
  output logic               cwr,
  output logic [2*LOG_W-1:0] caddr_wr,
  output logic [DW-1:0]      cdata_wr,
  output logic               crd,
  output logic [2*LOG_W-1:0] caddr_rd,
  input  logic [DW-1:0]      cdata_rd,
  output logic               csel
);

  localparam int C_KK   = K * K;
  localparam int C_HALF = K / 2;
  localparam int C_AW   = 2 * LOG_W;
  localparam int C_PW   = 2 * LOG_W - 2;
  localparam int C_ACW  = 2 * DW + 6;
  // Signed width wide enough for a centre coordinate plus any tap offset.
  localparam int C_OW   = LOG_W + 5;

  localparam logic [5:0]    C_LAST_TAP = 6'(C_KK);
  localparam logic [5:0]    C_POOL_END = 6'd4;
  localparam logic [2:0]    C_KM1      = 3'(K - 1);
  localparam logic [DW-1:0] C_POS_MAX  = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_WR0  = 3'd2,
    S_POOL = 3'd3,
    S_WR1  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                    r_busy;
  logic                    r_pool_en;
  logic                    r_pad_rep;
  logic [C_AW-1:0]         r_centre;
  logic [5:0]              r_cnt;
  logic [2:0]              r_tr;
  logic [2:0]              r_tc;
  logic                    r_tap_v;
  logic [5:0]              r_tap_idx;
  logic signed [C_ACW-1:0] r_acc;
  logic signed [DW-1:0]    r_kern [C_KK];
  logic signed [DW-1:0]    r_bias;
  logic [C_AW-1:0]         r_iaddr;
  logic [C_AW-1:0]         r_caddr_rd;
  logic [C_PW-1:0]         r_pidx;
  logic [DW-1:0]           r_max;

  logic signed [C_OW-1:0]  w_row;
  logic signed [C_OW-1:0]  w_col;
  logic                    w_tap_ok;
  logic [C_AW-1:0]         w_tap_addr;
  logic signed [DW-1:0]    w_coef;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [C_ACW-1:0] w_prod_ext;
  logic signed [C_ACW-1:0] w_acc_init;
  logic [DW-1:0]           w_conv_res;
  logic [DW-FRAC-1:0]      w_int;
  logic [DW-1:0]           w_pool_res;

  // Offset of tap index idx along one axis: DIL*(idx - K/2).
  function automatic logic signed [C_OW-1:0] f_tap_off(input logic [2:0] idx);
    int v;
    v = DIL * (int'(idx) - C_HALF);
    return C_OW'(v);
  endfunction

  function automatic logic f_in_range(input logic signed [C_OW-1:0] p);
    return ~|p[C_OW-1:LOG_W];
  endfunction

  function automatic logic [LOG_W-1:0] f_clamp(input logic signed [C_OW-1:0] p);
    if (p[C_OW-1])               return '0;
    else if (|p[C_OW-2:LOG_W])   return '1;
    else                         return p[LOG_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Tap address generation. Out-of-range taps are always clamped so the ROM
  // sees a legal address; in zero-pad mode they are marked not-valid and the
  // accumulate is skipped.
  // --------------------------------------------------------------------------
  assign w_row = $signed({{(C_OW-LOG_W){1'b0}}, r_centre[C_AW-1:LOG_W]}) + f_tap_off(r_tr);
  assign w_col = $signed({{(C_OW-LOG_W){1'b0}}, r_centre[LOG_W-1:0]})   + f_tap_off(r_tc);
  assign w_tap_ok   = r_pad_rep | (f_in_range(w_row) & f_in_range(w_col));
  assign w_tap_addr = {f_clamp(w_row), f_clamp(w_col)};

  always_comb begin
    w_coef = '0;
    for (int i = 0; i < C_KK; i++) begin
      if (r_tap_idx == 6'(i)) w_coef = r_kern[i];
    end
  end

  assign w_prod     = $signed(idata) * w_coef;
  assign w_prod_ext = {{(C_ACW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_acc_init = $signed({{(C_ACW-DW){r_bias[DW-1]}}, r_bias}) <<< FRAC;

  // ReLU then drop the fractional alignment of the accumulator.
  always_comb begin
    w_conv_res = '0;
    if (!r_acc[C_ACW-1]) begin
`ifdef CONV_SAT_EN
      if (|r_acc[C_ACW-1:DW-1+FRAC]) w_conv_res = C_POS_MAX;
      else                           w_conv_res = r_acc[DW-1+FRAC:FRAC];
`else
      w_conv_res = r_acc[DW-1+FRAC:FRAC];
`endif
    end
  end

  // Round the pooled maximum up to the next integer.
  assign w_int = r_max[DW-1:FRAC] + {{(DW-FRAC-1){1'b0}}, |r_max[FRAC-1:0]};

  always_comb begin
    w_pool_res = {w_int, {FRAC{1'b0}}};
`ifdef CONV_SAT_EN
    // Top bit of the source or of the rounded integer means the result no
    // longer fits as a positive DW-bit value.
    if (r_max[DW-1] | w_int[DW-FRAC-1]) w_pool_res = C_POS_MAX;
`endif
  end

  // --------------------------------------------------------------------------
  // FSM: state register and next-state / output decode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cwr         = 1'b0;
    crd         = 1'b1;
    csel        = 1'b0;
    caddr_wr    = '0;
    cdata_wr    = '0;
    case (r_state)
      S_IDLE: if (ready) w_state_nxt = S_CONV;
      S_CONV: if (r_cnt == C_LAST_TAP) w_state_nxt = S_WR0;
      S_WR0: begin
        cwr      = 1'b1;
        crd      = 1'b0;
        caddr_wr = r_centre;
        cdata_wr = w_conv_res;
        if (&r_centre) w_state_nxt = r_pool_en ? S_POOL : S_DONE;
        else           w_state_nxt = S_CONV;
      end
      S_POOL: if (r_cnt == C_POOL_END) w_state_nxt = S_WR1;
      S_WR1: begin
        cwr      = 1'b1;
        crd      = 1'b0;
        csel     = 1'b1;
        caddr_wr = {2'b00, r_pidx};
        cdata_wr = w_pool_res;
        if (&r_pidx) w_state_nxt = S_DONE;
        else         w_state_nxt = S_POOL;
      end
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_pool_en  <= 1'b0;
      r_pad_rep  <= 1'b0;
      r_centre   <= '0;
      r_cnt      <= '0;
      r_tr       <= '0;
      r_tc       <= '0;
      r_tap_v    <= 1'b0;
      r_tap_idx  <= '0;
      r_acc      <= '0;
      r_bias     <= '0;
      r_iaddr    <= '0;
      r_caddr_rd <= '0;
      r_pidx     <= '0;
      r_max      <= '0;
      for (int i = 0; i < C_KK; i++) r_kern[i] <= '0;
    end else begin
      if (kw_en && !r_busy) begin
        for (int i = 0; i < C_KK; i++) begin
          if (kw_addr == 6'(i)) r_kern[i] <= kw_data;
        end
        if (kw_addr == C_LAST_TAP) r_bias <= kw_data;
      end

      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_busy    <= 1'b1;
            r_pool_en <= pool_en;
            r_pad_rep <= pad_rep;
            r_centre  <= '0;
            r_cnt     <= '0;
            r_tr      <= '0;
            r_tc      <= '0;
            r_tap_v   <= 1'b0;
            r_acc     <= w_acc_init;
          end
        end

        // Address for tap r_cnt is issued now; its product is accumulated
        // in the following cycle using the registered tap index.
        S_CONV: begin
          if (r_tap_v) r_acc <= r_acc + w_prod_ext;
          if (r_cnt != C_LAST_TAP) begin
            r_iaddr   <= w_tap_addr;
            r_tap_v   <= w_tap_ok;
            r_tap_idx <= r_cnt;
            r_cnt     <= r_cnt + 6'd1;
            if (r_tc == C_KM1) begin
              r_tc <= '0;
              r_tr <= r_tr + 3'd1;
            end else begin
              r_tc <= r_tc + 3'd1;
            end
          end else begin
            r_tap_v <= 1'b0;
          end
        end

        S_WR0: begin
          if (!(&r_centre)) begin
            r_centre <= r_centre + C_AW'(1);
            r_cnt    <= '0;
            r_tr     <= '0;
            r_tc     <= '0;
            r_tap_v  <= 1'b0;
            r_acc    <= w_acc_init;
          end else if (r_pool_en) begin
            r_pidx <= '0;
            r_cnt  <= '0;
            r_max  <= '0;
          end
        end

        // Reads 0..3 walk the 2x2 block; reads land one cycle later, so the
        // max is updated on counts 1..4.
        S_POOL: begin
          if (r_cnt != C_POOL_END) begin
            r_caddr_rd <= {r_pidx[C_PW-1:LOG_W-1], r_cnt[1], r_pidx[LOG_W-2:0], r_cnt[0]};
            r_cnt      <= r_cnt + 6'd1;
          end
          if ((r_cnt != 6'd0) && (cdata_rd > r_max)) r_max <= cdata_rd;
        end

        S_WR1: begin
          if (!(&r_pidx)) begin
            r_pidx <= r_pidx + C_PW'(1);
            r_cnt  <= '0;
            r_max  <= '0;
          end
        end

        S_DONE: r_busy <= 1'b0;

        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy     = r_busy;
  assign iaddr    = r_iaddr;
  assign caddr_rd = r_caddr_rd;

endmodule
`default_nettype wire

// File: tb/tb_conv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pool_engine
// Purpose  : Directed self-checking bench for conv_pool_engine on a 16x16
//            image with K=5, DIL=2. Provides the image ROM and the two-bank
//            layer RAM, and compares layer outputs to hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pool_engine;

  localparam int LOG_W     = 4;
  localparam int K         = 5;
  localparam int DIL       = 2;
  localparam int DW        = 13;
  localparam int FRAC      = 4;
  localparam int N         = 16;
  localparam int NPIX      = 256;
  localparam int NPOOL     = 64;
  localparam int RUN_LIMIT = 20000;
  localparam int CYC_NOPOOL = NPIX * 27 + 1;
  localparam int CYC_POOL   = NPIX * 27 + NPOOL * 6 + 1;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          ready   = 1'b0;
  logic          kw_en   = 1'b0;
  logic [5:0]    kw_addr = '0;
  logic [DW-1:0] kw_data = '0;
  logic          pool_en = 1'b0;
  logic          pad_rep = 1'b0;
  logic          busy, cwr, crd, csel;
  logic [7:0]    iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0] idata, cdata_wr, cdata_rd;

  logic [DW-1:0] rom   [NPIX];
  logic [DW-1:0] bank0 [NPIX];
  logic [DW-1:0] bank1 [NPIX];
  logic          fill_req = 1'b0;
  logic [DW-1:0] fill_val = '0;
  int            w0_cnt = 0;
  int            w1_cnt = 0;

  int exp0 [NPIX];
  int exp1 [NPOOL];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign idata    = rom[iaddr];
  assign cdata_rd = bank0[caddr_rd];

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < NPIX; i++) begin
        bank0[i] <= fill_val;
        bank1[i] <= fill_val;
      end
    end else if (cwr) begin
      if (csel) bank1[caddr_wr] <= cdata_wr;
      else      bank0[caddr_wr] <= cdata_wr;
    end
    if (cwr) begin
      if (csel) w1_cnt <= w1_cnt + 1;
      else      w0_cnt <= w0_cnt + 1;
    end
  end

  conv_pool_engine #(
    .LOG_W(LOG_W), .K(K), .DIL(DIL), .DW(DW), .FRAC(FRAC)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .kw_en(kw_en), .kw_addr(kw_addr), .kw_data(kw_data),
    .pool_en(pool_en), .pad_rep(pad_rep),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic kw_write(input int a, input int d);
    kw_en = 1'b1; kw_addr = 6'(a); kw_data = DW'(d);
    @(posedge clk); #1;
    kw_en = 1'b0;
  endtask

  task automatic load_kernel(input int tap_all, input int centre, input int bias);
    for (int t = 0; t < K*K; t++) kw_write(t, (t == (K*K)/2) ? centre : tap_all);
    kw_write(K*K, bias);
  endtask

  task automatic fill_banks(input int v);
    fill_val = DW'(v); fill_req = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
  endtask

  task automatic start_run(input logic p, input logic r);
    pool_en = p; pad_rep = r; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; pool_en = 1'b0; pad_rep = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < RUN_LIMIT) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic image_random();
    for (int i = 0; i < NPIX; i++) rom[i] = DW'($urandom);
  endtask

  task automatic image_const(input int v);
    for (int i = 0; i < NPIX; i++) rom[i] = DW'(v);
  endtask

  // ---------------- reference model ----------------
  function automatic int f_roundup(input int v);
    int ip;
    ip = v >> FRAC;
    if ((v & ((1 << FRAC) - 1)) != 0) ip++;
    ip = ip << FRAC;
`ifdef CONV_SAT_EN
    if (ip > 4095) ip = 4095;
`else
    ip = ip & 32'h1FFF;
`endif
    return ip;
  endfunction

  task automatic model_relu();
    for (int i = 0; i < NPIX; i++) exp0[i] = rom[i][DW-1] ? 0 : int'(rom[i]);
  endtask

  task automatic model_pool();
    int m, v;
    for (int pr = 0; pr < N/2; pr++) begin
      for (int pc = 0; pc < N/2; pc++) begin
        m = 0;
        for (int d = 0; d < 4; d++) begin
          v = exp0[(2*pr + d/2)*N + 2*pc + d%2];
          if (v > m) m = v;
        end
        exp1[pr*(N/2) + pc] = f_roundup(m);
      end
    end
  endtask

  // Kernel and image both 1.0 (16): each valid tap contributes 16 to the output.
  task automatic model_all16(input logic rep);
    int cnt, rr, cc;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        cnt = 0;
        for (int dr = 0; dr < K; dr++) begin
          for (int dc = 0; dc < K; dc++) begin
            rr = r + DIL*(dr - K/2);
            cc = c + DIL*(dc - K/2);
            if (rep || (rr >= 0 && rr < N && cc >= 0 && cc < N)) cnt++;
          end
        end
        exp0[r*N + c] = cnt * 16;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (crd !== 1'b1)       begin errors++; $display("FAIL rst_crd got %b want 1", crd); end
    checks++; if (cwr !== 1'b0)       begin errors++; $display("FAIL rst_cwr got %b want 0", cwr); end
    checks++; if (csel !== 1'b0)      begin errors++; $display("FAIL rst_csel got %b want 0", csel); end
    checks++; if (iaddr !== 8'h00)    begin errors++; $display("FAIL rst_iaddr got %h want 00", iaddr); end
    checks++; if (caddr_rd !== 8'h00) begin errors++; $display("FAIL rst_caddr_rd got %h want 00", caddr_rd); end
    checks++; if (caddr_wr !== 8'h00) begin errors++; $display("FAIL rst_caddr_wr got %h want 00", caddr_wr); end
    checks++; if (cdata_wr !== '0)    begin errors++; $display("FAIL rst_cdata_wr got %h want 0", cdata_wr); end
    apply_reset();
  endtask

  task automatic test_identity_pool();
    int n, s0, s1;
    apply_reset();
    image_random();
    rom[0]  = 13'h0011; rom[1]  = 13'h0025; rom[16] = 13'h0005; rom[17] = 13'h0018;
    rom[34] = 13'h0FFF; rom[35] = 13'h0100; rom[50] = 13'h0007; rom[51] = 13'h0000;
    model_relu();
    model_pool();
    fill_banks(13'h1555);
    load_kernel(0, 16, 0);
    s0 = w0_cnt; s1 = w1_cnt;
    start_run(1'b1, 1'b0);
    wait_idle(n);
    checks++; if (n != CYC_POOL) begin errors++; $display("FAIL id_busy_cycles got %0d want %0d", n, CYC_POOL); end
    checks++; if (w0_cnt - s0 != NPIX) begin errors++; $display("FAIL id_l0_writes got %0d want %0d", w0_cnt - s0, NPIX); end
    checks++; if (w1_cnt - s1 != NPOOL) begin errors++; $display("FAIL id_l1_writes got %0d want %0d", w1_cnt - s1, NPOOL); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (bank0[i] !== DW'(exp0[i])) begin errors++; $display("FAIL id_l0[%0d] got %h want %h", i, bank0[i], DW'(exp0[i])); end
    end
    for (int i = 0; i < NPOOL; i++) begin
      checks++;
      if (bank1[i] !== DW'(exp1[i])) begin errors++; $display("FAIL id_l1[%0d] got %h want %h", i, bank1[i], DW'(exp1[i])); end
    end
    checks++; if (bank1[0] !== 13'h0030) begin errors++; $display("FAIL pool_block0 got %h want 0030", bank1[0]); end
`ifdef CONV_SAT_EN
    checks++; if (bank1[9] !== 13'h0FFF) begin errors++; $display("FAIL pool_top got %h want 0fff", bank1[9]); end
`else
    checks++; if (bank1[9] !== 13'h1000) begin errors++; $display("FAIL pool_top got %h want 1000", bank1[9]); end
`endif
  endtask

  task automatic test_all16(input logic rep);
    int n, s0, s1;
    apply_reset();
    image_const(16);
    model_all16(rep);
    fill_banks(13'h0ABC);
    load_kernel(16, 16, 0);
    s0 = w0_cnt; s1 = w1_cnt;
    start_run(1'b0, rep);
    wait_idle(n);
    checks++; if (n != CYC_NOPOOL) begin errors++; $display("FAIL a16_busy_cycles rep=%0b got %0d want %0d", rep, n, CYC_NOPOOL); end
    checks++; if (w0_cnt - s0 != NPIX) begin errors++; $display("FAIL a16_l0_writes got %0d want %0d", w0_cnt - s0, NPIX); end
    checks++; if (w1_cnt != s1) begin errors++; $display("FAIL a16_l1_writes got %0d want 0", w1_cnt - s1); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (bank0[i] !== DW'(exp0[i])) begin errors++; $display("FAIL a16_l0[%0d] rep=%0b got %0d want %0d", i, rep, bank0[i], exp0[i]); end
    end
    if (rep) begin
      checks++; if (bank0[0] !== 13'd400)   begin errors++; $display("FAIL rep_corner got %0d want 400", bank0[0]); end
      checks++; if (bank0[255] !== 13'd400) begin errors++; $display("FAIL rep_far_corner got %0d want 400", bank0[255]); end
    end else begin
      checks++; if (bank0[0] !== 13'd144)   begin errors++; $display("FAIL zp_corner got %0d want 144", bank0[0]); end
      checks++; if (bank0[136] !== 13'd400) begin errors++; $display("FAIL zp_centre got %0d want 400", bank0[136]); end
      checks++; if (bank0[8] !== 13'd240)   begin errors++; $display("FAIL zp_edge got %0d want 240", bank0[8]); end
    end
  endtask

  task automatic test_bias_relu();
    int n, s1;
    apply_reset();
    image_random();
    fill_banks(13'h0ABC);
    load_kernel(0, 0, 13'h1FF4);
    s1 = w1_cnt;
    start_run(1'b1, 1'b0);
    wait_idle(n);
    checks++; if (n != CYC_POOL) begin errors++; $display("FAIL bias_busy_cycles got %0d want %0d", n, CYC_POOL); end
    checks++; if (w1_cnt - s1 != NPOOL) begin errors++; $display("FAIL bias_l1_writes got %0d want %0d", w1_cnt - s1, NPOOL); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (bank0[i] !== '0) begin errors++; $display("FAIL bias_l0[%0d] got %h want 0", i, bank0[i]); end
    end
    for (int i = 0; i < NPOOL; i++) begin
      checks++;
      if (bank1[i] !== '0) begin errors++; $display("FAIL bias_l1[%0d] got %h want 0", i, bank1[i]); end
    end
  endtask

  task automatic test_abort_rerun();
    int n, s0;
    apply_reset();
    image_random();
    model_relu();
    load_kernel(0, 16, 0);
    fill_banks(13'h0ABC);
    start_run(1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (cwr !== 1'b0)       begin errors++; $display("FAIL abort_cwr got %b want 0", cwr); end
    checks++; if (crd !== 1'b1)       begin errors++; $display("FAIL abort_crd got %b want 1", crd); end
    checks++; if (iaddr !== 8'h00)    begin errors++; $display("FAIL abort_iaddr got %h want 00", iaddr); end
    checks++; if (caddr_rd !== 8'h00) begin errors++; $display("FAIL abort_caddr_rd got %h want 00", caddr_rd); end
    s0 = w0_cnt;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (w0_cnt != s0) begin errors++; $display("FAIL abort_writes got %0d want 0", w0_cnt - s0); end
    reset = 1'b1;
    @(posedge clk); #1;
    load_kernel(0, 16, 0);
    fill_banks(13'h0ABC);
    s0 = w0_cnt;
    start_run(1'b0, 1'b0);
    // All of these arrive while busy and must be ignored.
    kw_write((K*K)/2, 0);
    kw_write(K*K, 13'h1F00);
    ready = 1'b1; pool_en = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; pool_en = 1'b0;
    wait_idle(n);
    checks++; if (n >= RUN_LIMIT) begin errors++; $display("FAIL rerun_timeout got %0d want <%0d", n, RUN_LIMIT); end
    checks++; if (w0_cnt - s0 != NPIX) begin errors++; $display("FAIL rerun_writes got %0d want %0d", w0_cnt - s0, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (bank0[i] !== DW'(exp0[i])) begin errors++; $display("FAIL rerun_l0[%0d] got %h want %h", i, bank0[i], DW'(exp0[i])); end
    end
  endtask

  initial begin
    image_const(0);
    test_reset();
    test_identity_pool();
    test_all16(1'b0);
    test_all16(1'b1);
    test_bias_relu();
    test_abort_rerun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
